// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores bytes into a TX FIFO over the data bus,
// and a serialiser drains them onto TXD. Status/divisor registers read back combinationally.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd867
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [1:0]  WR,
   input  logic [31:0] D_IN_ADDR,
   input  logic [31:0] D_IN,
   input  logic [31:0] D_OUT_ADDR,
   output logic [31:0] D_OUT,
   output logic        TXD,
   output logic        IRQ,
   output logic [1:0]  state_dbg
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

   state_t          state, state_next;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count, count_next;
   logic            ovf;
   logic [15:0]     divisor;
   logic [15:0]     bit_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shifter, shift_next;
   logic            txd_q, txd_next, irq_q;
   logic            tick, pop, push, bit_load;
   logic            wr_hit, wr_txdata, wr_status, wr_div, rd_hit;
   logic            fifo_empty, fifo_full, busy;
   logic            unused_bits;

   assign unused_bits = ^{D_IN[31:16], D_IN_ADDR[1:0], D_OUT_ADDR[1:0]};

   assign wr_hit    = (D_IN_ADDR[31:4] == BASE_ADDR[31:4]) && (WR != 2'b00);
   assign wr_txdata = wr_hit && (D_IN_ADDR[3:2] == 2'd0);
   assign wr_status = wr_hit && (D_IN_ADDR[3:2] == 2'd1);
   assign wr_div    = wr_hit && (D_IN_ADDR[3:2] == 2'd2);
   assign rd_hit    = (D_OUT_ADDR[31:4] == BASE_ADDR[31:4]);

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CW'(FIFO_DEPTH));
   assign busy       = (state != IDLE);
   assign tick       = (bit_cnt == 16'd0);
   // A full FIFO still accepts a byte when the serialiser pops on the same edge.
   assign push       = wr_txdata && (!fifo_full || pop);

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= D_IN[7:0];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count_next;
      end
   end

   // Overflow set takes priority over a software clear on the same edge.
   always_ff @(posedge CLK) begin
      if (RST)                        ovf <= 1'b0;
      else if (wr_txdata && !push)    ovf <= 1'b1;
      else if (wr_status && D_IN[3])  ovf <= 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RST)                 divisor <= DIV_RESET;
      else if (wr_div) begin
         if (WR == 2'b01)      divisor[7:0] <= D_IN[7:0];
         else                  divisor      <= D_IN[15:0];
      end
   end

   // FSM: state register
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_next;
   end

   // FSM: next state
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (!fifo_empty) state_next = START;
         START: if (tick) state_next = DATA;
         DATA:  if (tick && bit_idx == 3'd7) state_next = STOP;
         STOP:  if (tick) state_next = fifo_empty ? IDLE : START;
         default: state_next = IDLE;
      endcase
   end

   // FSM: outputs; TXD is registered from the next-cycle line level.
   always_comb begin
      pop        = (state_next == START) && (state == IDLE || state == STOP);
      bit_load   = (state_next != IDLE) && ((state_next != state) || tick);
      shift_next = shifter;
      if (pop)                       shift_next = mem[rd_ptr];
      else if (state == DATA && tick) shift_next = {1'b0, shifter[7:1]};
      case (state_next)
         START:   txd_next = 1'b0;
         DATA:    txd_next = shift_next[0];
         default: txd_next = 1'b1;
      endcase
   end

   // Bit timer reloads from DIVISOR at every bit boundary, so divisor edits apply from the next bit.
   always_ff @(posedge CLK) begin
      if (RST) begin
         bit_cnt <= 16'd0;
         bit_idx <= 3'd0;
         shifter <= 8'd0;
         txd_q   <= 1'b1;
         irq_q   <= 1'b1;
      end else begin
         if (bit_load)              bit_cnt <= divisor;
         else if (bit_cnt != 16'd0) bit_cnt <= bit_cnt - 16'd1;
         if (state != DATA)         bit_idx <= 3'd0;
         else if (tick)             bit_idx <= bit_idx + 3'd1;
         shifter <= shift_next;
         txd_q   <= txd_next;
         irq_q   <= (state_next == IDLE) && (count_next == '0);
      end
   end

   always_comb begin
      D_OUT = 32'd0;
      if (rd_hit) begin
         case (D_OUT_ADDR[3:2])
            2'd1:    D_OUT = {16'd0, 8'(count), 4'd0, ovf, busy, fifo_full, fifo_empty};
            2'd2:    D_OUT = {16'd0, divisor};
            default: D_OUT = 32'd0;
         endcase
      end
   end

   assign TXD       = txd_q;
   assign IRQ       = irq_q;
   assign state_dbg = state;

endmodule
